// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED
  } fetch_state_t;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_pc_reg.sv
// Program counter register: a load overrides the sequential increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc_out
);

  // The increment wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out <= RESET_VECTOR;
    end else if (load_en) begin
      pc_out <= load_addr;
    end else if (inc_en) begin
      pc_out <= pc_out + XLEN'(INST_BYTES);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Stall-aware fetch sequencer: one outstanding memory request, one-entry
// instruction buffer towards decode, trap > redirect > sequential PC update.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic            halt_req,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            misaligned_err,
  output logic            halted
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. imem_req_valid may drop without a transfer only on a redirect;
  // inst_valid holds with stable data/pc until consumed or redirected.

  fetch_state_t    state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic            redir_any;
  logic            redir_misaligned;
  logic [XLEN-1:0] redir_target;
  logic            pc_load;
  logic            pc_inc;

  always_comb begin
    redir_any        = trap_valid | redirect_valid;
    redir_misaligned = !trap_valid && redirect_valid && !is_aligned(redirect_addr[1:0]);
    redir_target     = redirect_addr;
    if (trap_valid || redir_misaligned) begin
      redir_target = TRAP_VECTOR;
    end
  end

  // A consume that coincides with a redirect lands on the redirect target.
  assign pc_load       = redir_any && (state != IDLE);
  assign pc_inc        = (state == HOLD) && inst_ready && !redir_any;
  assign imem_req_addr = pc;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_en  (pc_load),
    .load_addr(redir_target),
    .inc_en   (pc_inc),
    .pc_out   (pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_data      <= '0;
      inst_pc        <= '0;
      misaligned_err <= 1'b0;
      halted         <= 1'b0;
    end else begin
      misaligned_err <= (state != IDLE) && redir_misaligned;
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            // The old address was issued; its response must be swallowed.
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            if (redir_any) begin
              drop <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (redir_any) begin
              drop           <= 1'b0;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else if (drop) begin
              drop <= 1'b0;
              if (halt_req) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                state          <= REQ;
                imem_req_valid <= 1'b1;
              end
            end else begin
              inst_data  <= imem_rsp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (redir_any) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redir_any) begin
            inst_valid     <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            if (halt_req) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (redir_any || !halt_req) begin
            halted         <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          drop           <= 1'b0;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          halted         <= 1'b0;
        end
      endcase
    end
  end

  a_no_req_while_halted : assert property (@(posedge clk) disable iff (!reset_n)
    !(halted && imem_req_valid));

  a_no_req_while_holding : assert property (@(posedge clk) disable iff (!reset_n)
    !(inst_valid && imem_req_valid));

  a_inst_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (inst_valid && !inst_ready && !redirect_valid && !trap_valid)
      |=> (inst_valid && $stable(inst_data) && $stable(inst_pc)));

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a random
// run checked against an instruction-stream model of the fetch rules.
module tb_fetch_controller;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic        halt_req;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misaligned_err;
  logic        halted;

  always #5 clk = ~clk;

  fetch_controller #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .trap_valid    (trap_valid),
    .halt_req      (halt_req),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .misaligned_err(misaligned_err),
    .halted        (halted)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_ready_pct = 100;
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory model / drivers ----------------
  task automatic mem_step();
    cyc++;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_req_ready = ($urandom_range(0, 99) < mem_ready_pct);
    if (imem_req_valid) begin
      n_cmp++;
      if (pend || imem_rsp_valid) begin
        n_err++;
        $display("FAIL single_outstanding: req_valid=1 addr=%h while a response is owed (t=%0t)",
                 imem_req_addr, $time);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = $urandom_range(mem_lat_min, mem_lat_max);
      acc_q.push_back(imem_req_addr);
      acc_cyc   = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mem_step();
  endtask

  task automatic reset_assert();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    trap_valid     = 1'b0;
    halt_req       = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend           = 1'b0;
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_release();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_assert();
    reset_release();
  endtask

  task automatic wait_inst(input int bound, output bit ok);
    ok = inst_valid;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = inst_valid;
    end
  endtask

  task automatic wait_accept(input int bound, output bit ok);
    ok = (acc_q.size() > 0);
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = (acc_q.size() > 0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_ready_pct = 100; mem_lat_min = 1; mem_lat_max = 1;
    @(negedge clk);
    reset_assert();
    #1;
    n_cmp++;
    if ({imem_req_valid, inst_valid, misaligned_err, halted} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: req/inst/mis/halt=%b expected 0000",
               {imem_req_valid, inst_valid, misaligned_err, halted});
    end
    n_cmp++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_inst: data=%h pc=%h expected 0/0", inst_data, inst_pc);
    end
    n_cmp++;
    if (imem_req_addr !== RESET_VECTOR) begin
      n_err++;
      $display("FAIL reset_pc: addr=%h expected %h", imem_req_addr, RESET_VECTOR);
    end
    reset_release();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_cycle: req_valid=%b expected 0", imem_req_valid);
    end
    step();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_VECTOR) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h expected 1/%h", imem_req_valid, imem_req_addr, RESET_VECTOR);
    end
  endtask

  task automatic test_sequential();
    int ninst;
    mem_ready_pct = 100; mem_lat_min = 1; mem_lat_max = 1;
    do_reset();
    inst_ready = 1'b1;
    exp_q = {32'h0, 32'h4, 32'h8};
    ninst = 0;
    for (int i = 0; i < 40 && ninst < 3; i++) begin
      step();
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== exp_q[0] || inst_data !== mem_fn(exp_q[0])) begin
          n_err++;
          $display("FAIL seq_inst: pc=%h data=%h expected %h/%h", inst_pc, inst_data, exp_q[0], mem_fn(exp_q[0]));
        end
        n_cmp++;
        if (cyc - acc_cyc != 2) begin
          n_err++;
          $display("FAIL seq_latency: %0d cycles expected 2", cyc - acc_cyc);
        end
        void'(exp_q.pop_front());
        ninst++;
      end
    end
    n_cmp++;
    if (ninst != 3) begin
      n_err++;
      $display("FAIL seq_timeout: %0d instructions expected 3", ninst);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (acc_q.size() <= k || acc_q[k] !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL seq_req_addr[%0d]: got %h expected %h", k,
                 (acc_q.size() > k) ? acc_q[k] : 32'hxxxx_xxxx, 32'(4 * k));
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] d, p;
    mem_ready_pct = 100; mem_lat_min = 1; mem_lat_max = 1;
    do_reset();
    wait_inst(20, ok);
    n_cmp++;
    if (!ok || inst_pc !== RESET_VECTOR) begin
      n_err++;
      $display("FAIL stall_first: valid=%b pc=%h expected 1/%h", ok, inst_pc, RESET_VECTOR);
    end
    d = inst_data;
    p = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_data !== d || inst_pc !== p || imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h pc=%h req=%b expected 1/%h/%h/0",
                 i, inst_valid, inst_data, inst_pc, imem_req_valid, d, p);
      end
    end
    n_cmp++;
    if (imem_req_addr !== p) begin
      n_err++;
      $display("FAIL stall_pc: addr=%h expected %h", imem_req_addr, p);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== p + 32'd4) begin
      n_err++;
      $display("FAIL stall_release: inst_valid=%b req=%b addr=%h expected 0/1/%h",
               inst_valid, imem_req_valid, imem_req_addr, p + 32'd4);
    end
  endtask

  task automatic test_wait_redirect();
    bit ok;
    bit seen;
    mem_ready_pct = 100; mem_lat_min = 4; mem_lat_max = 4;
    do_reset();
    inst_ready = 1'b1;
    wait_accept(10, ok);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    acc_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 20 && acc_q.size() == 0; i++) begin
      step();
      if (inst_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!ok || seen) begin
      n_err++;
      $display("FAIL wait_drop: accepted=%b inst_valid_seen=%b expected 1/0", ok, seen);
    end
    n_cmp++;
    if (acc_q.size() == 0 || acc_q[0] !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL wait_redir_addr: got %h expected 00000200",
               (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx);
    end
    inst_ready = 1'b0;
    mem_lat_min = 1; mem_lat_max = 1;
    wait_inst(20, ok);
    n_cmp++;
    if (!ok || inst_pc !== 32'h0000_0200 || inst_data !== mem_fn(32'h0000_0200)) begin
      n_err++;
      $display("FAIL wait_redir_inst: valid=%b pc=%h data=%h expected 1/00000200/%h",
               ok, inst_pc, inst_data, mem_fn(32'h0000_0200));
    end
  endtask

  task automatic test_priority();
    bit ok;
    mem_ready_pct = 0; mem_lat_min = 1; mem_lat_max = 1;
    do_reset();
    step();
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0000_0300;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== TRAP_VECTOR || misaligned_err !== 1'b0) begin
      n_err++;
      $display("FAIL prio_trap: req=%b addr=%h mis=%b expected 1/%h/0",
               imem_req_valid, imem_req_addr, misaligned_err, TRAP_VECTOR);
    end
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0500;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_addr !== 32'h0000_0500 || misaligned_err !== 1'b0) begin
      n_err++;
      $display("FAIL prio_redirect: addr=%h mis=%b expected 00000500/0", imem_req_addr, misaligned_err);
    end
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_addr !== TRAP_VECTOR || misaligned_err !== 1'b1) begin
      n_err++;
      $display("FAIL misaligned: addr=%h mis=%b expected %h/1", imem_req_addr, misaligned_err, TRAP_VECTOR);
    end
    step();
    n_cmp++;
    if (misaligned_err !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_pulse: mis=%b expected 0", misaligned_err);
    end
    mem_ready_pct = 100;
    wait_inst(20, ok);
    n_cmp++;
    if (!ok || inst_pc !== TRAP_VECTOR) begin
      n_err++;
      $display("FAIL misaligned_fetch: valid=%b pc=%h expected 1/%h", ok, inst_pc, TRAP_VECTOR);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_ready_pct = 0; mem_lat_min = 1; mem_lat_max = 1;
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    mem_ready_pct = 100;
    wait_inst(20, ok);
    n_cmp++;
    if (!ok || inst_pc !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_inst: valid=%b pc=%h expected 1/fffffffc", ok, inst_pc);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap_addr: req=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_halt();
    bit ok;
    logic [31:0] p;
    mem_ready_pct = 100; mem_lat_min = 1; mem_lat_max = 1;
    do_reset();
    wait_inst(20, ok);
    p = inst_pc;
    halt_req = 1'b1; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt_state[%0d]: halted=%b req=%b inst=%b expected 1/0/0", i, halted, imem_req_valid, inst_valid);
      end
      step();
    end
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL halt_redirect_exit: halted=%b req=%b addr=%h expected 0/1/00000040", halted, imem_req_valid, imem_req_addr);
    end
    wait_inst(20, ok);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    n_cmp++;
    if (!ok || halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_rehalt: inst_seen=%b halted=%b expected 1/1", ok, halted);
    end
    halt_req = 1'b0;
    step();
    n_cmp++;
    if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0044) begin
      n_err++;
      $display("FAIL halt_resume: halted=%b req=%b addr=%h expected 0/1/00000044 (first pc %h)",
               halted, imem_req_valid, imem_req_addr, p);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    mem_ready_pct = 0; mem_lat_min = 4; mem_lat_max = 4;
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    mem_ready_pct = 100;
    acc_q.delete();
    wait_accept(10, ok);
    step();
    #2;
    reset_assert();
    #1;
    n_cmp++;
    if (!ok || {imem_req_valid, inst_valid, misaligned_err, halted} !== 4'b0000 ||
        imem_req_addr !== RESET_VECTOR) begin
      n_err++;
      $display("FAIL async_reset: accepted=%b flags=%b addr=%h expected 1/0000/%h",
               ok, {imem_req_valid, inst_valid, misaligned_err, halted}, imem_req_addr, RESET_VECTOR);
    end
    mem_lat_min = 1; mem_lat_max = 1;
    reset_release();
    wait_inst(20, ok);
    n_cmp++;
    if (!ok || inst_pc !== RESET_VECTOR || inst_data !== mem_fn(RESET_VECTOR)) begin
      n_err++;
      $display("FAIL reset_restart: valid=%b pc=%h data=%h expected 1/%h/%h",
               ok, inst_pc, inst_data, RESET_VECTOR, mem_fn(RESET_VECTOR));
    end
  endtask

  task automatic test_random();
    logic [31:0] model_pc;
    logic [31:0] tgt;
    bit          exp_mis;
    bit          do_redir;
    int          kind;
    int          n_deliv;
    mem_ready_pct = 70; mem_lat_min = 1; mem_lat_max = 3;
    do_reset();
    step();
    model_pc = RESET_VECTOR;
    exp_mis  = 1'b0;
    n_deliv  = 0;
    for (int i = 0; i < 2500; i++) begin
      n_cmp++;
      if (misaligned_err !== exp_mis) begin
        n_err++;
        $display("FAIL rand_misaligned[%0d]: got %b expected %b", i, misaligned_err, exp_mis);
      end
      inst_ready     = ($urandom_range(0, 1) == 1);
      redirect_valid = 1'b0;
      trap_valid     = 1'b0;
      do_redir       = ($urandom_range(0, 99) < 5);
      if (inst_valid && inst_ready) begin
        n_cmp++;
        if (inst_pc !== model_pc || inst_data !== mem_fn(model_pc)) begin
          n_err++;
          $display("FAIL rand_inst[%0d]: pc=%h data=%h expected %h/%h",
                   i, inst_pc, inst_data, model_pc, mem_fn(model_pc));
        end
        n_deliv++;
        if (!do_redir) model_pc = model_pc + 32'd4;
      end
      exp_mis = 1'b0;
      if (do_redir) begin
        kind = $urandom_range(0, 3);
        tgt  = $urandom & 32'hFFFF_FFFC;
        if (kind == 0) begin
          trap_valid     = 1'b1;
          redirect_valid = ($urandom_range(0, 1) == 1);
          redirect_addr  = $urandom;
          model_pc       = TRAP_VECTOR;
        end else if (kind == 1) begin
          redirect_valid = 1'b1;
          redirect_addr  = tgt | 32'($urandom_range(1, 3));
          model_pc       = TRAP_VECTOR;
          exp_mis        = 1'b1;
        end else begin
          redirect_valid = 1'b1;
          redirect_addr  = tgt;
          model_pc       = tgt;
        end
      end
      step();
    end
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
    inst_ready     = 1'b0;
    n_cmp++;
    if (n_deliv < 100) begin
      n_err++;
      $display("FAIL rand_progress: %0d instructions delivered, expected at least 100", n_deliv);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    trap_valid     = 1'b0;
    halt_req       = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_wait_redirect();
    test_priority();
    test_wrap();
    test_halt();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch. Owns the program counter register and drives a request/response handshake to instruction memory.
- Presents fetched instructions to decode with a valid/ready handshake.
- Applies branch redirects, trap redirects and halt requests with fixed priority.
- Sits between the branch/execute logic and instruction memory; replaces the free-running PC increment with a stall-aware sequencer.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active low.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_addr  in  32  branch/jump target.
- trap_valid  in  1  trap request; highest priority.
- halt_req  in  1  level; stop issuing new fetches.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address; equals current PC.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_data  out  32  buffered instruction.
- inst_pc  out  32  PC of inst_data.
- inst_ready  in  1  decode consumes instruction.
- misaligned_err  out  1  one-cycle pulse; redirect_addr[1:0] != 0.
- halted  out  1  high while in HALTED.

Behaviour:
Reset (asynchronous assert, synchronous release):
- pc = RESET_VECTOR, state = IDLE.
- imem_req_valid, inst_valid, misaligned_err, halted = 0.
- inst_data = 0, inst_pc = 0, drop flag = 0.

States:
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req_valid = 1, imem_req_addr = pc. On imem_req_ready = 1, go to WAIT next cycle. A request not yet accepted may be retracted by a redirect; the memory tolerates this.
- WAIT: on imem_rsp_valid:
  - If drop = 0: capture inst_data = imem_rsp_data and inst_pc = pc, then go to HOLD.
  - If drop = 1: discard the data, clear drop, then go to REQ, or to HALTED if halt_req is high.
- HOLD: inst_valid = 1 and inst_data/inst_pc stay stable. On inst_ready = 1, pc <= pc + 4, then go to REQ, or to HALTED if halt_req is high.
- HALTED: halted = 1 and no requests are issued. Exit to REQ when halt_req = 0 or on a redirect/trap.

Fetch-to-issue latency: minimum 2 cycles from request acceptance to inst_valid (zero-wait memory: accept in cycle N, response in N+1, inst_valid in N+2).

Redirect resolution (all states except IDLE), priority trap > redirect > sequential:
- trap_valid: new pc = TRAP_VECTOR.
- redirect_valid with redirect_addr[1:0] == 0: new pc = redirect_addr.
- redirect_valid with redirect_addr[1:0] != 0: new pc = TRAP_VECTOR and misaligned_err pulses for one cycle.

Effect of a redirect/trap by state:
- REQ, not accepted: next state REQ at the new pc.
- REQ, accepted the same cycle: the old address was issued; set drop = 1 and go to WAIT.
- WAIT: set drop = 1 and stay in WAIT until the response arrives. There is never more than one outstanding request.
- WAIT, with imem_rsp_valid the same cycle: discard the response and go to REQ at the new pc.
- HOLD: inst_valid deasserts next cycle and the state goes to REQ. If inst_ready is high the same cycle, the handshake still completes: the instruction counts as consumed, and pc = the redirect target, not pc + 4.
- HALTED: go to REQ at the new pc, even if halt_req is still high. Re-halt only at the next HOLD-consume or drop-WAIT boundary.

Other rules:
- pc + 4 wraps modulo 2^32: 32'hFFFF_FFFC is followed by 32'h0000_0000.
- halt_req is sampled only at those boundaries. An accepted request always completes its response.
- Reset asserted mid-operation returns to the reset state immediately. A response arriving after reset release while in IDLE/REQ is ignored.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, REQ, WAIT, HOLD, HALTED}; constants INST_BYTES = 4 and XLEN = 32.
- Sub-module pc_reg:
  - Ports: clk, reset_n, load_en, load_addr, inc_en, pc_out; parameter RESET_VECTOR.
  - load_en has priority over inc_en.

Test Plan:
- Reset release, memory always ready with a 1-cycle response, inst_ready = 1 -> imem_req_addr sequence 0x0, 0x4, 0x8; inst_pc matches with 2-cycle issue latency.
- inst_ready held low for 5 cycles in HOLD -> inst_valid, inst_data and inst_pc stable; no new imem_req_valid; pc advances only after inst_ready.
- redirect_valid with addr 0x200 while in WAIT, response arriving 3 cycles later -> response dropped, inst_valid stays 0, next request addr 0x200, drop cleared.
- Same cycle: trap_valid = 1, redirect_valid = 1 with addr 0x300 -> next request addr 0x100. Separately, redirect to 0x202 -> misaligned_err pulses 1 cycle, next request addr 0x100.
- pc forced to 0xFFFF_FFFC via redirect, then consume -> next request addr 0x0000_0000.
- halt_req high during HOLD, then consume -> HALTED, halted = 1, no requests. halt_req low -> REQ at pc + 4. Reset asserted in WAIT -> all outputs at reset values asynchronously, restart at RESET_VECTOR.
